// File: rtl/muxn_stream.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | muxn_stream: N-channel registered stream mux, fixed-select or round-robin |
// | Optional packet lock: MUXN_STREAM_PKT_LOCK_EN                             |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
module muxn_stream #(
    parameter int n        = 16,
    parameter int CHANNELS = 4,
    parameter int SW       = $clog2(CHANNELS)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [CHANNELS*n-1:0] in_data,
    input  logic [CHANNELS-1:0]   in_valid,
    output logic [CHANNELS-1:0]   in_ready,
`ifdef MUXN_STREAM_PKT_LOCK_EN
    input  logic [CHANNELS-1:0]   in_last,
`endif
    input  logic                  mode,
    input  logic [SW-1:0]         sel,
    output logic [n-1:0]          out_data,
    output logic                  out_valid,
    input  logic                  out_ready
);

    typedef enum logic [0:0] {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_t;

    state_t        r_state;
    state_t        w_state_next;
    logic [n-1:0]  r_data;
    logic [SW-1:0] r_ptr;

    logic          w_load;
    logic          w_sel_ok;
    logic          w_grant_ok;
    logic          w_accept;
    logic [SW-1:0] w_grant;
    logic [SW-1:0] w_rr_idx;
    logic [n-1:0]  w_grant_data;

`ifdef MUXN_STREAM_PKT_LOCK_EN
    logic          r_lock;
    logic [SW-1:0] r_lock_ch;
    logic          w_last;
`endif

    // Channel index a + b, wrapped into [0, CHANNELS) for any channel count.
    function automatic logic [SW-1:0] wrap_add(input logic [SW-1:0] a, input int b);
        int s;
        s = int'(a) + b;
        if (s >= CHANNELS) begin
            s = s - CHANNELS;
        end
        return s[SW-1:0];
    endfunction

    if ((1 << SW) > CHANNELS) begin : g_sel_check
        assign w_sel_ok = (int'(sel) < CHANNELS);
    end else begin : g_sel_full
        assign w_sel_ok = 1'b1;
    end

    assign w_load    = (r_state == ST_EMPTY) || out_ready;
    assign out_valid = (r_state == ST_FULL);
    assign out_data  = r_data;

    // Descending scan: the final overwrite is the nearest valid channel at or above ptr.
    always_comb begin
        w_rr_idx = r_ptr;
        for (int k = CHANNELS - 1; k >= 0; k--) begin
            if (in_valid[wrap_add(r_ptr, k)]) begin
                w_rr_idx = wrap_add(r_ptr, k);
            end
        end
    end

    always_comb begin
        w_grant    = sel;
        w_grant_ok = w_sel_ok;
        if (mode) begin
            w_grant    = w_rr_idx;
            w_grant_ok = 1'b1;
`ifdef MUXN_STREAM_PKT_LOCK_EN
            if (r_lock) begin
                w_grant = r_lock_ch;
            end
`endif
        end
    end

    always_comb begin
        in_ready     = '0;
        w_grant_data = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (w_grant == SW'(i)) begin
                in_ready[i]  = rst_n && w_load && w_grant_ok;
                w_grant_data = in_data[i*n +: n];
            end
        end
    end

    assign w_accept = |(in_valid & in_ready);

`ifdef MUXN_STREAM_PKT_LOCK_EN
    assign w_last = in_last[w_grant];
`endif

    always_comb begin
        w_state_next = r_state;
        if (w_accept) begin
            w_state_next = ST_FULL;
        end else if (out_ready) begin
            w_state_next = ST_EMPTY;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_EMPTY;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_data    <= '0;
            r_ptr     <= '0;
`ifdef MUXN_STREAM_PKT_LOCK_EN
            r_lock    <= 1'b0;
            r_lock_ch <= '0;
`endif
        end else if (w_accept) begin
            r_data <= w_grant_data;
            if (mode) begin
`ifdef MUXN_STREAM_PKT_LOCK_EN
                // Pointer moves only once the packet has finished.
                if (w_last) begin
                    r_ptr  <= wrap_add(w_grant, 1);
                    r_lock <= 1'b0;
                end else begin
                    r_lock    <= 1'b1;
                    r_lock_ch <= w_grant;
                end
`else
                r_ptr <= wrap_add(w_grant, 1);
`endif
            end
        end
    end

endmodule
`default_nettype wire
